// File: rtl/sb_rx_mux_pkg.sv
// Shared constants, state encoding and the round-robin search for the
// switchboard receive multiplexer.
package sb_rx_mux_pkg;

  localparam logic VM_ALWAYS = 1'b0;
  localparam logic VM_RANDOM = 1'b1;

  // Fibonacci LFSR, taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t LOCKED = 1'b1;

  localparam int MAX_N = 64;

  // First set bit of req scanning ptr+1, ptr+2, ... modulo n; 0 if none.
  function automatic int rr_next(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sb_rx_mux_buf_if.sv
// Channel-side streams, merged output stream and valid-mode configuration
// of the switchboard receive multiplexer.
interface sb_rx_mux_buf_if #(
  parameter int DW = 416,
  parameter int N  = 4
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N*DW-1:0] in_data;
  logic [N*32-1:0] in_dest;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;

  logic [DW-1:0]   out_data;
  logic [31:0]     out_dest;
  logic            out_last;
  logic [CW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  logic            cfg_we;
  logic            cfg_valid_mode;

  modport slave (
    input  in_data, in_dest, in_last, in_valid,
    output in_ready,
    output out_data, out_dest, out_last, out_chan, out_valid,
    input  out_ready,
    input  cfg_we, cfg_valid_mode
  );

  modport master (
    output in_data, in_dest, in_last, in_valid,
    input  in_ready,
    input  out_data, out_dest, out_last, out_chan, out_valid,
    output out_ready,
    output cfg_we, cfg_valid_mode
  );

endinterface

// File: rtl/sb_rx_mux_fifo.sv
// Single-channel synchronous FIFO with count-based full/empty flags and
// no write-to-read bypass.
module sb_rx_mux_fifo #(
  parameter int W     = 449,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CNTW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CNTW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/sb_rx_mux_buf.sv
// N-channel switchboard receive stage: per-channel FIFOs merged round-robin
// onto one output with packet atomicity and an optional LFSR valid throttle.
module sb_rx_mux_buf
  import sb_rx_mux_pkg::*;
#(
  parameter int DW                 = 416,
  parameter int N                  = 4,
  parameter int DEPTH              = 4,
  parameter bit VALID_MODE_DEFAULT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  sb_rx_mux_buf_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = DW + 33;

  logic [N-1:0]  full, empty, push, pop, avail;
  logic [N-1:0]  fresh_q, fresh_d;
  logic [W-1:0]  head [N];
  logic [W-1:0]  head_sel;
  state_t        state_q, state_d;
  logic [CW-1:0] owner_q, owner_d, rr_q, rr_d;
  logic          mode_q, mode_d, hold_q, hold_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          gate, out_valid, xfer, head_last;

  assign bus.in_ready = ~full & {N{~rst}};
  assign push         = bus.in_valid & bus.in_ready;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sb_rx_mux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   ({bus.in_last[i], bus.in_dest[i*32 +: 32], bus.in_data[i*DW +: DW]}),
      .full  (full[i]),
      .pop   (pop[i]),
      .dout  (head[i]),
      .empty (empty[i])
    );
  end

  assign head_sel  = head[owner_q];
  assign head_last = head_sel[W-1];

  assign gate      = (mode_q == VM_ALWAYS) | lfsr_q[0] | hold_q;
  assign out_valid = ~rst & (state_q == LOCKED) & ~empty[owner_q] & gate;
  assign xfer      = out_valid & bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? head_sel[DW-1:0]   : '0;
  assign bus.out_dest  = out_valid ? head_sel[DW +: 32] : '0;
  assign bus.out_last  = out_valid & head_last;
  assign bus.out_chan  = owner_q;

  // A FIFO filled from empty is offered to the arbiter one cycle after its
  // first push; data already waiting is picked in the single bubble cycle.
  assign fresh_d = push & empty;
  assign avail   = ~empty & ~fresh_q;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pop = '0;
    if (xfer) pop[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|avail) begin
          owner_d = CW'(rr_next(MAX_N'(avail), int'(rr_q), N));
          state_d = LOCKED;
        end
      end
      default: begin
        if (xfer && head_last) begin
          state_d = IDLE;
          rr_d    = owner_q;
        end
      end
    endcase
  end

  always_comb begin
    mode_d = bus.cfg_we ? bus.cfg_valid_mode : mode_q;
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    hold_d = hold_q;
    if (xfer)           hold_d = 1'b0;
    else if (out_valid) hold_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= CW'(N - 1);
      hold_q  <= 1'b0;
      mode_q  <= VALID_MODE_DEFAULT;
      lfsr_q  <= LFSR_SEED;
      fresh_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      fresh_q <= fresh_d;
    end
  end

endmodule
